fb_plane_writer: RTL and testbench
==================================

Name: fb_plane_writer

Overview:
- Write-side counterpart of the video scanout path.
- Accepts a serial stream of 4-bit colour indices and packs each group of 8 pixels into four bitplane bytes.
- Writes those bytes into video SRAM using the same plane/column/row address layout that the scanout reads.
- Used for capture, blitter and test-pattern fill of the 0x8000–0xFFFF framebuffer; SRAM writes occur only in granted memory slots.

Parameters:
- NPLANES, 4, bitplanes per pixel group. Fixed; other values are unsupported.
- PLANE_BASE, 1'b1, address bit 15 of every write (framebuffer window 0x8000).

Ports:
- clk24  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; latches row, col0, nbytes and begins a line.
- row  in  8  framebuffer row (address bits 7:0).
- col0  in  5  starting column (address bits 12:8).
- nbytes  in  5  bytes per plane for this line; 0 means 32.
- pix_valid  in  1  pix_data is valid.
- pix_data  in  4  colour index {p0,p1,p2,p3}: bit3 goes to plane 0, bit0 goes to plane 3.
- pix_ready  out  1  block accepts a pixel this cycle.
- mem_slot  in  1  SRAM write slot granted this cycle.
- SRAM_ADDR  out  16  write address.
- SRAM_DQ_OUT  out  8  write data.
- SRAM_WE  out  1  one-cycle write strobe.
- busy  out  1  line in progress.
- done  out  1  one-cycle pulse when the last byte of the line has been written.

Behaviour:
- Reset values: pix_ready=0, SRAM_WE=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, busy=0, done=0. The FSM goes to IDLE and all counters clear.
- Address form: {PLANE_BASE, plane[1:0], column[4:0], row[7:0]}.
- Bit order: the first pixel of a group occupies bit 7 of each plane byte; the 8th pixel occupies bit 0.
- Pixel transfer: a pixel is accepted when pix_valid & pix_ready are both high at a clk24 edge.
- Datapath: two stages.
  - Accumulator: four 8-bit shift registers plus a 3-bit pixel count.
  - Hold register: four bytes, a column value and a full flag.
  - On the 8th accepted pixel, the accumulator contents (including that pixel) move to the hold register in the same edge, provided the hold register is empty or is being emptied in that same cycle.
- pix_ready = busy & (pixels_remaining != 0) & !(accumulator has 7 pixels & hold full & hold not finishing this cycle).
- FSM states:
  - IDLE: on start, latch the parameters, set pixels_remaining = 8*nbytes (256 when nbytes=0), go to RUN; busy=1 from the next cycle.
  - RUN: fill and write concurrently. When pixels_remaining=0 and the hold register has drained, go to FIN.
  - FIN: pulse done for one cycle, clear busy, return to IDLE.
- Write issue:
  - While the hold register is full, each cycle with mem_slot=1 issues the next plane, in order 0,1,2,3.
  - Outputs are registered: the cycle after mem_slot was sampled, SRAM_WE=1 for exactly one cycle, with SRAM_ADDR and SRAM_DQ_OUT valid for that plane.
  - After plane 3 issues, the hold register clears and the column increments modulo 32 (31 wraps to 0; row unchanged).
- mem_slot while nothing is pending: SRAM_WE stays 0 and SRAM_ADDR/SRAM_DQ_OUT hold their last values.
- start while busy: ignored.
- pix_valid in IDLE, or after all pixels are accepted: ignored (pix_ready=0).
- Reset asserted mid-line: immediate abort. SRAM_WE is forced to 0, no partial plane writes complete, and done is not pulsed.
- Latency: for a single byte with mem_slot held high, the last SRAM_WE occurs 4 cycles after the 8th pixel is accepted, and done follows 1 cycle after that.

Test Plan:
- Reset, then start row=0x10, col0=3, nbytes=1, pixels F,0,F,0,F,0,F,0, mem_slot tied high -> four writes: 0x8310=AA, 0xA310=AA, 0xC310=AA, 0xE310=AA; then done; busy=0.
- Pixel stream 8,4,2,1,0,0,0,0 at row=0 col0=0 -> plane0 0x8000=80, plane1 0xA000=40, plane2 0xC000=20, plane3 0xE000=10 (confirms bit order and plane mapping).
- col0=31, nbytes=2, mem_slot high -> first group written at column 31 (0x9Fxx), second at column 0 (0x80xx); exactly 8 SRAM_WE pulses.
- Pixels driven continuously with mem_slot high one cycle in eight -> pix_ready drops to 0 when 7 pixels are held and the hold register is full. No pixel is lost or duplicated; written data matches the reference model for nbytes=0 (256 pixels, 128 writes).
- Second start pulse during RUN -> ignored; done pulses only once, after the first line completes.
- Reset asserted after the 2nd plane write of a group -> SRAM_WE=0 in the same cycle, busy=0, no done pulse. A subsequent start/line completes correctly.

Source files
------------

// File: rtl/fb_plane_writer.sv
// fb_plane_writer
// Packs a serial stream of 4-bit colour indices into bitplane bytes and
// writes them into the video SRAM framebuffer window. The address layout
// is {PLANE_BASE, plane, column, row}, the same layout the scanout reads.
// Each group of 8 pixels becomes one byte per plane. The first pixel of
// the group lands in bit 7. The planes are written in order 0..3, one per
// granted memory slot.

module fb_plane_writer #(
    parameter int   NPLANES    = 4,
    parameter logic PLANE_BASE = 1'b1
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  row,
    input  logic [4:0]  col0,
    input  logic [4:0]  nbytes,
    input  logic        pix_valid,
    input  logic [3:0]  pix_data,
    output logic        pix_ready,
    input  logic        mem_slot,
    output logic [15:0] SRAM_ADDR,
    output logic [7:0]  SRAM_DQ_OUT,
    output logic        SRAM_WE,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // Line parameters and progress
    logic [7:0]  row_r;
    logic [4:0]  col_r;
    logic [8:0]  remaining_r;
    logic        busy_r;
    logic        done_r;

    // Accumulator stage: one shift register per plane plus the pixel count
    logic [7:0]  acc_r [NPLANES];
    logic [7:0]  acc_shift_s [NPLANES];
    logic [2:0]  acc_cnt_r;

    // Hold stage: one completed group waiting to be written
    logic [7:0]  hold_r [NPLANES];
    logic [4:0]  hold_col_r;
    logic        hold_full_r;
    logic [1:0]  plane_r;

    // Registered SRAM write port
    logic        sram_we_r;
    logic [15:0] sram_addr_r;
    logic [7:0]  sram_dq_r;

    // Control strobes
    logic        start_s;
    logic        issue_s;
    logic        hold_finish_s;
    logic        acc_stall_s;
    logic        pix_ready_s;
    logic        accept_s;
    logic        group_done_s;
    logic        line_end_s;
    logic [8:0]  init_remaining_s;

    // Handshake and pipeline control decoded from the current state
    always_comb begin
        start_s       = 1'b0;
        issue_s       = 1'b0;
        hold_finish_s = 1'b0;
        acc_stall_s   = 1'b0;
        pix_ready_s   = 1'b0;
        accept_s      = 1'b0;
        group_done_s  = 1'b0;
        line_end_s    = 1'b0;

        start_s = (state_r == ST_IDLE) & start;
        // A plane is issued on every granted slot while a group is held
        issue_s = hold_full_r & mem_slot;
        // The hold register empties on the edge that issues plane 3
        hold_finish_s = issue_s & (plane_r == 2'd3);
        // An 8th pixel has nowhere to go while the hold register stays full
        acc_stall_s = (acc_cnt_r == 3'd7) & hold_full_r & ~hold_finish_s;
        pix_ready_s = busy_r & (remaining_r != 9'd0) & ~acc_stall_s;
        accept_s = pix_valid & pix_ready_s;
        group_done_s = accept_s & (acc_cnt_r == 3'd7);
        line_end_s = (state_r == ST_RUN) & (remaining_r == 9'd0) & ~hold_full_r;
    end

    // Pixel count for the new line; an nbytes value of 0 encodes 32 bytes
    always_comb begin
        init_remaining_s = 9'd0;
        if (nbytes == 5'd0) begin
            init_remaining_s = 9'd256;
        end else begin
            init_remaining_s = {1'b0, nbytes, 3'b000};
        end
    end

    // Next accumulator contents: shift the incoming pixel's plane bits in
    always_comb begin
        for (int k = 0; k < NPLANES; k++) begin
            acc_shift_s[k] = {acc_r[k][6:0], pix_data[NPLANES-1-k]};
        end
    end

    // Next-state logic of the line sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (line_end_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Line parameters, remaining-pixel count, busy and done flags
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            row_r       <= 8'd0;
            col_r       <= 5'd0;
            remaining_r <= 9'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= line_end_s;
            if (start_s) begin
                row_r       <= row;
                col_r       <= col0;
                remaining_r <= init_remaining_s;
                busy_r      <= 1'b1;
            end else begin
                if (accept_s) begin
                    remaining_r <= remaining_r - 9'd1;
                end
                // The column advances as each group leaves the accumulator
                if (group_done_s) begin
                    col_r <= col_r + 5'd1;
                end
                if (state_r == ST_FIN) begin
                    busy_r <= 1'b0;
                end
            end
        end
    end

    // Accumulator: shift in accepted pixels and count them modulo 8
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NPLANES; k++) begin
                acc_r[k] <= 8'd0;
            end
            acc_cnt_r <= 3'd0;
        end else if (start_s) begin
            acc_cnt_r <= 3'd0;
        end else if (accept_s) begin
            for (int k = 0; k < NPLANES; k++) begin
                acc_r[k] <= acc_shift_s[k];
            end
            acc_cnt_r <= acc_cnt_r + 3'd1;
        end
    end

    // Hold register: take a completed group, then drain it one plane per slot
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NPLANES; k++) begin
                hold_r[k] <= 8'd0;
            end
            hold_col_r  <= 5'd0;
            hold_full_r <= 1'b0;
            plane_r     <= 2'd0;
        end else begin
            if (issue_s) begin
                plane_r <= plane_r + 2'd1;
            end
            // Loading wins over clearing when both happen on the same edge
            if (group_done_s) begin
                for (int k = 0; k < NPLANES; k++) begin
                    hold_r[k] <= acc_shift_s[k];
                end
                hold_col_r  <= col_r;
                hold_full_r <= 1'b1;
            end else if (hold_finish_s) begin
                hold_full_r <= 1'b0;
            end
        end
    end

    // SRAM write port: one registered strobe per issued plane, and the
    // address and data hold their last values when nothing is issued
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            sram_we_r   <= 1'b0;
            sram_addr_r <= 16'd0;
            sram_dq_r   <= 8'd0;
        end else if (issue_s) begin
            sram_we_r   <= 1'b1;
            sram_addr_r <= {PLANE_BASE, plane_r, hold_col_r, row_r};
            sram_dq_r   <= hold_r[plane_r];
        end else begin
            sram_we_r   <= 1'b0;
        end
    end

    assign pix_ready   = pix_ready_s;
    assign SRAM_WE     = sram_we_r;
    assign SRAM_ADDR   = sram_addr_r;
    assign SRAM_DQ_OUT = sram_dq_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_fb_plane_writer.sv
// Directed testbench for fb_plane_writer.
module tb_fb_plane_writer;

    logic        clk24 = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  row;
    logic [4:0]  col0;
    logic [4:0]  nbytes;
    logic        pix_valid;
    logic [3:0]  pix_data;
    logic        mem_slot;
    wire         pix_ready;
    wire [15:0]  SRAM_ADDR;
    wire [7:0]   SRAM_DQ_OUT;
    wire         SRAM_WE;
    wire         busy;
    wire         done;

    int checks = 0;
    int failures = 0;

    logic [3:0]  pixbuf [0:255];
    logic [15:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int          done_cnt = 0;

    int last_acc_iter;
    int last_we_iter;
    int done_iter;
    int sent_total;
    bit got_done;
    bit stall_seen;

    always #5 clk24 = ~clk24;

    fb_plane_writer #(.NPLANES(4), .PLANE_BASE(1'b1)) dut (
        .clk24       (clk24),
        .reset       (reset),
        .start       (start),
        .row         (row),
        .col0        (col0),
        .nbytes      (nbytes),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .mem_slot    (mem_slot),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_WE     (SRAM_WE),
        .busy        (busy),
        .done        (done)
    );

    // Log every SRAM write and count done pulses
    always @(negedge clk24) begin
        if (SRAM_WE === 1'b1) begin
            wa_q.push_back(SRAM_ADDR);
            wd_q.push_back(SRAM_DQ_OUT);
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
        end
    end

    function automatic logic [15:0] exp_addr(input logic [7:0] r, input logic [4:0] c,
                                             input int g, input int p);
        logic [4:0] cc;
        logic [1:0] pp;
        cc = c + 5'(g);
        pp = 2'(p);
        return {1'b1, pp, cc, r};
    endfunction

    function automatic logic [7:0] exp_data(input int g, input int p);
        logic [7:0] b;
        logic [3:0] px;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            px = pixbuf[8*g+i];
            b[7-i] = px[3-p];
        end
        return b;
    endfunction

    task automatic run_line(input logic [7:0] r, input logic [4:0] c, input logic [4:0] nb,
                            input int slot_period, input int extra_start);
        int npx;
        int cyc;
        bit acc;
        npx = (nb == 5'd0) ? 256 : 8 * int'(nb);
        wa_q.delete();
        wd_q.delete();
        sent_total = 0; got_done = 1'b0; stall_seen = 1'b0;
        last_acc_iter = -1; last_we_iter = -1; done_iter = -1;
        row = r; col0 = c; nbytes = nb; start = 1'b1; pix_valid = 1'b0; mem_slot = 1'b0;
        @(posedge clk24); #1;
        start = 1'b0;
        cyc = 0;
        while (!got_done && cyc < 6000) begin
            mem_slot  = ((cyc % slot_period) == 0);
            pix_valid = 1'b1;
            pix_data  = (sent_total < npx) ? pixbuf[sent_total] : 4'hF;
            if (cyc == extra_start) begin
                start = 1'b1; row = 8'hFF; col0 = 5'd7; nbytes = 5'd3;
            end else begin
                start = 1'b0; row = r; col0 = c; nbytes = nb;
            end
            @(negedge clk24);
            if (SRAM_WE === 1'b1) last_we_iter = cyc;
            if (done === 1'b1) begin
                got_done = 1'b1;
                done_iter = cyc;
            end
            acc = (pix_valid && pix_ready === 1'b1);
            if (pix_ready !== 1'b1 && sent_total < npx && (sent_total % 8) == 7) stall_seen = 1'b1;
            @(posedge clk24); #1;
            if (acc) begin
                sent_total++;
                last_acc_iter = cyc;
            end
            cyc++;
        end
        pix_valid = 1'b0; mem_slot = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk24);
        #1;
    endtask

    task automatic test_reset();
        bit bad_ready;
        bit bad_we;
        reset = 1'b1; start = 1'b0; row = 8'd0; col0 = 5'd0; nbytes = 5'd0;
        pix_valid = 1'b1; pix_data = 4'hF; mem_slot = 1'b1;
        repeat (2) @(posedge clk24);
        @(negedge clk24);
        checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_pix_ready: got %b expected 0", pix_ready); end
        checks++; if (SRAM_WE !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", SRAM_WE); end
        checks++; if (SRAM_ADDR !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h expected 0000", SRAM_ADDR); end
        checks++; if (SRAM_DQ_OUT !== 8'h00) begin failures++; $display("FAIL reset_dq: got %h expected 00", SRAM_DQ_OUT); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        @(posedge clk24); #1;
        reset = 1'b0;
        bad_ready = 1'b0; bad_we = 1'b0;
        repeat (4) begin
            @(negedge clk24);
            if (pix_ready !== 1'b0) bad_ready = 1'b1;
            if (SRAM_WE !== 1'b0) bad_we = 1'b1;
        end
        checks++; if (bad_ready) begin failures++; $display("FAIL idle_pix_ready: got 1 expected 0"); end
        checks++; if (bad_we) begin failures++; $display("FAIL idle_slot_we: got 1 expected 0"); end
        @(posedge clk24); #1;
        pix_valid = 1'b0; mem_slot = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] ea [0:3];
        int d0;
        ea[0] = 16'h8310; ea[1] = 16'hA310; ea[2] = 16'hC310; ea[3] = 16'hE310;
        for (int i = 0; i < 8; i++) pixbuf[i] = (i % 2 == 0) ? 4'hF : 4'h0;
        d0 = done_cnt;
        run_line(8'h10, 5'd3, 5'd1, 1, -1);
        checks++; if (!got_done) begin failures++; $display("FAIL basic_done_timeout: got none expected done"); end
        checks++; if (wa_q.size() != 4) begin failures++; $display("FAIL basic_wr_count: got %0d expected 4", wa_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wa_q[k] !== ea[k] || wd_q[k] !== 8'hAA) begin
                    failures++;
                    $display("FAIL basic_write%0d: got %h=%h expected %h=aa", k, wa_q[k], wd_q[k], ea[k]);
                end
            end
        end
        checks++; if (last_we_iter - last_acc_iter != 5) begin failures++; $display("FAIL basic_we_latency: got %0d expected 5", last_we_iter - last_acc_iter); end
        checks++; if (done_iter - last_we_iter != 1) begin failures++; $display("FAIL basic_done_latency: got %0d expected 1", done_iter - last_we_iter); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (sent_total != 8) begin failures++; $display("FAIL basic_accepted: got %0d expected 8", sent_total); end
    endtask

    task automatic test_bit_order();
        logic [15:0] ea [0:3];
        logic [7:0]  ed [0:3];
        ea[0] = 16'h8000; ea[1] = 16'hA000; ea[2] = 16'hC000; ea[3] = 16'hE000;
        ed[0] = 8'h80; ed[1] = 8'h40; ed[2] = 8'h20; ed[3] = 8'h10;
        pixbuf[0] = 4'h8; pixbuf[1] = 4'h4; pixbuf[2] = 4'h2; pixbuf[3] = 4'h1;
        for (int i = 4; i < 8; i++) pixbuf[i] = 4'h0;
        run_line(8'h00, 5'd0, 5'd1, 1, -1);
        checks++; if (wa_q.size() != 4) begin failures++; $display("FAIL order_wr_count: got %0d expected 4", wa_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wa_q[k] !== ea[k] || wd_q[k] !== ed[k]) begin
                    failures++;
                    $display("FAIL order_plane%0d: got %h=%h expected %h=%h", k, wa_q[k], wd_q[k], ea[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_col_wrap();
        for (int i = 0; i < 16; i++) pixbuf[i] = 4'(i * 3 + 1);
        run_line(8'h5A, 5'd31, 5'd2, 1, -1);
        checks++; if (!got_done) begin failures++; $display("FAIL wrap_done_timeout: got none expected done"); end
        checks++; if (wa_q.size() != 8) begin failures++; $display("FAIL wrap_wr_count: got %0d expected 8", wa_q.size()); end
        else begin
            checks++; if (wa_q[0] !== 16'h9F5A) begin failures++; $display("FAIL wrap_first_addr: got %h expected 9f5a", wa_q[0]); end
            checks++; if (wa_q[4] !== 16'h805A) begin failures++; $display("FAIL wrap_second_addr: got %h expected 805a", wa_q[4]); end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wa_q[k] !== exp_addr(8'h5A, 5'd31, k / 4, k % 4) || wd_q[k] !== exp_data(k / 4, k % 4)) begin
                    failures++;
                    $display("FAIL wrap_write%0d: got %h=%h expected %h=%h", k, wa_q[k], wd_q[k],
                             exp_addr(8'h5A, 5'd31, k / 4, k % 4), exp_data(k / 4, k % 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        for (int i = 0; i < 256; i++) pixbuf[i] = 4'(i * 5 + i / 16);
        run_line(8'h33, 5'd4, 5'd0, 8, -1);
        checks++; if (!got_done) begin failures++; $display("FAIL bp_done_timeout: got none expected done"); end
        checks++; if (sent_total != 256) begin failures++; $display("FAIL bp_accepted: got %0d expected 256", sent_total); end
        checks++; if (!stall_seen) begin failures++; $display("FAIL bp_stall: got no stall expected pix_ready=0 at 7 held"); end
        checks++; if (wa_q.size() != 128) begin failures++; $display("FAIL bp_wr_count: got %0d expected 128", wa_q.size()); end
        else begin
            bad = 0;
            for (int k = 0; k < 128; k++) begin
                if (wa_q[k] !== exp_addr(8'h33, 5'd4, k / 4, k % 4) || wd_q[k] !== exp_data(k / 4, k % 4)) begin
                    if (bad == 0) $display("FAIL bp_write%0d: got %h=%h expected %h=%h", k, wa_q[k], wd_q[k],
                                           exp_addr(8'h33, 5'd4, k / 4, k % 4), exp_data(k / 4, k % 4));
                    bad++;
                end
            end
            checks++; if (bad != 0) begin failures++; $display("FAIL bp_data: got %0d bad writes expected 0", bad); end
        end
    endtask

    task automatic test_start_ignored();
        int d0;
        for (int i = 0; i < 8; i++) pixbuf[i] = 4'(9 + i);
        d0 = done_cnt;
        run_line(8'h21, 5'd9, 5'd1, 1, 3);
        checks++; if (wa_q.size() != 4) begin failures++; $display("FAIL restart_wr_count: got %0d expected 4", wa_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wa_q[k] !== exp_addr(8'h21, 5'd9, 0, k) || wd_q[k] !== exp_data(0, k)) begin
                    failures++;
                    $display("FAIL restart_write%0d: got %h=%h expected %h=%h", k, wa_q[k], wd_q[k],
                             exp_addr(8'h21, 5'd9, 0, k), exp_data(0, k));
                end
            end
        end
        repeat (20) @(posedge clk24);
        #1;
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL restart_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int we_seen;
        int sent;
        int d0;
        bit acc;
        for (int i = 0; i < 8; i++) pixbuf[i] = 4'(15 - 2 * i);
        d0 = done_cnt;
        row = 8'h44; col0 = 5'd2; nbytes = 5'd1; start = 1'b1; pix_valid = 1'b0; mem_slot = 1'b1;
        @(posedge clk24); #1;
        start = 1'b0;
        cyc = 0; we_seen = 0; sent = 0;
        while (we_seen < 2 && cyc < 200) begin
            pix_valid = (sent < 8);
            pix_data  = (sent < 8) ? pixbuf[sent] : 4'h0;
            @(negedge clk24);
            if (SRAM_WE === 1'b1) we_seen++;
            acc = (pix_valid && pix_ready === 1'b1);
            @(posedge clk24); #1;
            if (acc) sent++;
            cyc++;
        end
        checks++; if (we_seen < 2) begin failures++; $display("FAIL abort_timeout: got %0d writes expected 2", we_seen); end
        checks++; if (SRAM_WE !== 1'b1) begin failures++; $display("FAIL abort_third_we: got %b expected 1", SRAM_WE); end
        reset = 1'b1;
        #1;
        checks++; if (SRAM_WE !== 1'b0) begin failures++; $display("FAIL abort_we: got %b expected 0", SRAM_WE); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
        pix_valid = 1'b0; mem_slot = 1'b0;
        repeat (3) @(posedge clk24);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk24);
        #1;
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0); end
        for (int i = 0; i < 8; i++) pixbuf[i] = 4'(i + 3);
        run_line(8'h45, 5'd6, 5'd1, 1, -1);
        checks++; if (!got_done) begin failures++; $display("FAIL after_abort_done: got none expected done"); end
        checks++; if (wa_q.size() != 4) begin failures++; $display("FAIL after_abort_count: got %0d expected 4", wa_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wa_q[k] !== exp_addr(8'h45, 5'd6, 0, k) || wd_q[k] !== exp_data(0, k)) begin
                    failures++;
                    $display("FAIL after_abort_write%0d: got %h=%h expected %h=%h", k, wa_q[k], wd_q[k],
                             exp_addr(8'h45, 5'd6, 0, k), exp_data(0, k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit_order();
        test_col_wrap();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
